// File: rtl/encdec_pkg.sv
// Shared types and constants for the 4-line encoder/decoder family.
// N request lines map to W-bit binary codes; only N=4, W=2 is supported.
package encdec_pkg;

    localparam int N = 4;
    localparam int W = 2;

    typedef logic [N-1:0] req_t;
    typedef logic [W-1:0] code_t;

    // One-hot expansion of a code, e.g. 2 -> 4'b0100.
    function automatic req_t code_to_onehot(input code_t c);
        req_t oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

endpackage : encdec_pkg

// File: rtl/encode_4to2_seq_prio_sel4.sv
// prio_sel4: combinational 4-way priority selector.
// Returns the first set bit of pending, searching upward from base and
// wrapping 3 -> 0. With base=0 this is plain lowest-index-wins priority.
module prio_sel4
    import encdec_pkg::*;
(
    input  logic [N-1:0] pending,
    input  logic [W-1:0] base,
    output logic [W-1:0] sel_code,
    output logic [N-1:0] sel_onehot,
    output logic         sel_any
);

    logic  found;
    code_t idx;

    // Walk the four positions starting at base; first hit wins.
    always_comb begin
        sel_code = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = base + code_t'(i);
            if (!found && pending[idx]) begin
                sel_code = idx;
                found    = 1'b1;
            end
        end
        sel_any    = |pending;
        sel_onehot = sel_any ? code_to_onehot(sel_code) : '0;
    end

endmodule : prio_sel4

// File: rtl/encode_4to2_seq.sv
// encode_4to2_seq: sequential 4-to-2 encoder.
// Request pulses are merged into a pending register and drained one at a
// time as a 2-bit code over a valid/ready handshake.
// Optional build macro ENCODE_ROUND_ROBIN_EN: round-robin selection with a
// pointer holding last_served+1; when undefined, lowest index wins and no
// pointer register exists.
module encode_4to2_seq
    import encdec_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    req_t  pending_q, pending_d;
    code_t code_q, code_d;
    logic  valid_q, valid_d;
    logic  overflow_q, overflow_d;

    req_t  req_gated;
    req_t  clr;
    logic  load;

    code_t base;
    code_t sel_code;
    req_t  sel_onehot;
    logic  sel_any;

`ifdef ENCODE_ROUND_ROBIN_EN
    code_t ptr_q, ptr_d;

    assign base = ptr_q;

    // Pointer advances past whatever was just loaded into the output stage.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = sel_code + code_t'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign base = '0;
`endif

    prio_sel4 u_sel (
        .pending    (pending_q),
        .base       (base),
        .sel_code   (sel_code),
        .sel_onehot (sel_onehot),
        .sel_any    (sel_any)
    );

    // Next-state: capture, overflow detection and output-stage load.
    always_comb begin
        req_gated = enable ? req : '0;
        load      = (!valid_q || ready) && sel_any;
        clr       = load ? sel_onehot : '0;

        // Set is ORed in after the clear, so a same-cycle re-request survives.
        pending_d  = (pending_q & ~clr) | req_gated;
        overflow_d = overflow_q | (|(req_gated & pending_q & ~clr));

        code_d  = code_q;
        valid_d = valid_q;
        if (load) begin
            code_d  = sel_code;
            valid_d = 1'b1;
        end else if (ready) begin
            // Output accepted (or idle) and nothing left to present.
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule : encode_4to2_seq

// File: tb/tb_encode_4to2_seq.sv
// Self-checking bench for encode_4to2_seq (default fixed-priority build).
// Expected codes are queued when stimulus is driven and popped by a monitor
// whenever the DUT completes a valid/ready transfer.
module tb_encode_4to2_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [1:0] code;
    logic       valid;
    logic       ready;
    logic [3:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    encode_4to2_seq dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    // Transfer monitor: sampled mid-cycle, ahead of the accepting edge.
    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected got code=%0d required=none", code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (code !== e[1:0]) begin
                    failures++;
                    $display("FAIL xfer_code got=%0d required=%0d", code, e);
                end else begin
                    $display("xfer code=%0d ok", code);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = 4'b1111; ready = 1'b1;
        step(); step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b required=0", valid); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rst_pending got=%b required=0000", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0b required=0", overflow); end
        checks++; if (code !== 2'd0) begin failures++; $display("FAIL rst_code got=%0d required=0", code); end
        reset = 1'b0; req = 4'b0000;
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%0b required=0", valid); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rel_pending got=%b required=0000", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rel_overflow got=%0b required=0", overflow); end
    endtask

    task automatic test_single_pulse();
        ready = 1'b1; req = 4'b0100;
        exp_q.push_back(2);
        step();
        req = 4'b0000;
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pending got=%b required=0100", pending); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b required=0", valid); end
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd2) begin failures++; $display("FAIL single_out got valid=%0b code=%0d required valid=1 code=2", valid, code); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%0b required=0", valid); end
    endtask

    task automatic test_multi();
        ready = 1'b1; req = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        step();
        req = 4'b0000;
        checks++; if (pending !== 4'b1011) begin failures++; $display("FAIL multi_pending got=%b required=1011", pending); end
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b1010) begin failures++; $display("FAIL multi_c0 got valid=%0b code=%0d pending=%b required 1/0/1010", valid, code, pending); end
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd1) begin failures++; $display("FAIL multi_c1 got valid=%0b code=%0d required 1/1", valid, code); end
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd3) begin failures++; $display("FAIL multi_c3 got valid=%0b code=%0d required 1/3", valid, code); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL multi_end got=%0b required=0", valid); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1; req = 4'b1010;
        exp_q.push_back(1); exp_q.push_back(3);
        step();
        req = 4'b0000;
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd1) begin failures++; $display("FAIL b2b_c1 got valid=%0b code=%0d required 1/1", valid, code); end
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd3) begin failures++; $display("FAIL b2b_c3 got valid=%0b code=%0d required 1/3", valid, code); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b required=0", valid); end
    endtask

    task automatic test_backpressure();
        ready = 1'b0; req = 4'b0011;
        exp_q.push_back(0); exp_q.push_back(1);
        step();
        req = 4'b0000;
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b0010) begin failures++; $display("FAIL bp_load got valid=%0b code=%0d pending=%b required 1/0/0010", valid, code, pending); end
        step(); step();
        checks++; if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b0010) begin failures++; $display("FAIL bp_hold got valid=%0b code=%0d pending=%b required 1/0/0010", valid, code, pending); end
        ready = 1'b1;
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd1 || pending !== 4'b0000) begin failures++; $display("FAIL bp_next got valid=%0b code=%0d pending=%b required 1/1/0000", valid, code, pending); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_end got=%0b required=0", valid); end
    endtask

    task automatic test_overflow();
        ready = 1'b0; req = 4'b0001;
        exp_q.push_back(0); exp_q.push_back(0);
        step(); step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b required=0", overflow); end
        step();
        req = 4'b0000;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b required=1", overflow); end
        checks++; if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b0001) begin failures++; $display("FAIL ovf_state got valid=%0b code=%0d pending=%b required 1/0/0001", valid, code, pending); end
        ready = 1'b1;
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b0000) begin failures++; $display("FAIL ovf_drain got valid=%0b code=%0d pending=%b required 1/0/0000", valid, code, pending); end
        step();
        checks++; if (valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got valid=%0b overflow=%0b required 0/1", valid, overflow); end
    endtask

    task automatic test_set_wins();
        reset = 1'b1;
        step();
        reset = 1'b0; ready = 1'b1; req = 4'b0001;
        exp_q.push_back(0); exp_q.push_back(0);
        step(); step();
        req = 4'b0000;
        checks++; if (pending !== 4'b0001 || valid !== 1'b1 || code !== 2'd0) begin failures++; $display("FAIL setwin_keep got pending=%b valid=%0b code=%0d required 0001/1/0", pending, valid, code); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL setwin_ovf got=%0b required=0", overflow); end
        step();
        checks++; if (pending !== 4'b0000 || valid !== 1'b1 || code !== 2'd0) begin failures++; $display("FAIL setwin_again got pending=%b valid=%0b code=%0d required 0000/1/0", pending, valid, code); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL setwin_end got=%0b required=0", valid); end
    endtask

    task automatic test_enable_and_reset();
        enable = 1'b0; ready = 1'b1; req = 4'b1111;
        step();
        req = 4'b0000; enable = 1'b1;
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL en_pending got=%b required=0000", pending); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL en_valid got=%0b required=0", valid); end
        ready = 1'b0; req = 4'b1100;
        step();
        req = 4'b0000;
        step();
        checks++; if (valid !== 1'b1 || code !== 2'd2 || pending !== 4'b1000) begin failures++; $display("FAIL mr_before got valid=%0b code=%0d pending=%b required 1/2/1000", valid, code, pending); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (valid !== 1'b0 || pending !== 4'b0000 || code !== 2'd0) begin failures++; $display("FAIL mr_after got valid=%0b code=%0d pending=%b required 0/0/0000", valid, code, pending); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req = 4'b0000; ready = 1'b0;
        test_reset();
        test_single_pulse();
        test_multi();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_set_wins();
        test_enable_and_reset();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_encode_4to2_seq

// File: doc/encode_4to2_seq.md
Name: encode_4to2_seq

Overview:
- Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 decoder.
- Captures single-cycle request pulses on 4 lines into a pending register.
- Emits each pending request, one at a time, as a 2-bit code with a valid/ready handshake.
- Sits between event sources (e.g. decoder outputs, button strobes) and a consumer that needs a binary index stream.

Parameters:
- N, 4, number of request lines. Fixed at 4 for this block; only the value 4 is supported.
- W, 2, code width, equal to log2(N).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, global gate; req is ignored while enable=0.
- req, input, 4, request pulses; bit k means "event k".
- code, output, 2, binary index of the request being presented.
- valid, output, 1, code is valid.
- ready, input, 1, consumer accepts code when valid and ready are both 1 at a clock edge.
- pending, output, 4, registered pending request bits (not yet loaded to output).
- overflow, output, 1, sticky flag: a request arrived on a bit already pending.

Behaviour:
- Reset (reset=1 at an edge):
  - code=0, valid=0, pending=0, overflow=0.
  - Priority pointer resets to 0.
  - Reset mid-handshake drops all pending work and any presented code.
- Capture:
  - Each edge: pending_next = (pending & ~clr) | (enable ? req : 0).
  - clr is the one-hot bit loaded into the output stage this cycle.
  - Set wins over clear on the same bit in the same cycle: the bit stays pending and is served again later.
- Overflow:
  - Set when enable=1 and req[k]=1 while pending[k]=1 and the bit is not being cleared that cycle.
  - Remains 1 until reset.
  - Input bits already pending are merged; no counting.
- Output load:
  - Condition: (valid=0 or ready=1) and pending!=0.
  - At the edge: code <= selected index, valid <= 1, and that pending bit is cleared.
  - If the condition holds with pending==0 and ready=1, valid <= 0.
  - While valid=1 and ready=0, code and valid hold.
- Selection (default, fixed priority): lowest set index of pending wins. bit0 > bit1 > bit2 > bit3.
- Latency:
  - A req pulse sampled at edge t appears in pending after edge t.
  - With an idle output, valid=1 with that code after edge t+1 (2-edge latency).
- Throughput: one code per cycle while ready=1 and pending is non-empty.
- Back-to-back: a multi-bit pulse such as req=4'b1010 produces codes 1 then 3 on consecutive cycles.

Optional Feature:
- Macro: ENCODE_ROUND_ROBIN_EN.
- Defined:
  - A 2-bit pointer holds last_served+1 (mod 4).
  - Selection is the first set bit of pending searched from the pointer upward, wrapping 3 to 0.
  - The pointer updates on every output load.
  - Pointer reset value is 0.
- Undefined: fixed lowest-index priority as above, and no pointer register exists.

Decomposition:
- Shared package encdec_pkg holds:
  - constants N=4, W=2;
  - typedef req_t (logic [3:0]);
  - typedef code_t (logic [1:0]).
- Natural sub-module: prio_sel4.
  - Purely combinational.
  - Inputs: pending[3:0] and base pointer[1:0].
  - Outputs: sel_code[1:0], sel_onehot[3:0], sel_any.
  - base is tied to 0 when the macro is off.

Test Plan:
- Reset: hold reset=1 with req=4'b1111, enable=1 -> valid=0, pending=0, overflow=0 during reset and on the first edge after release.
- Single pulse: req=4'b0100 for 1 cycle, ready=1 -> valid=1, code=2 exactly 2 edges later; valid=0 the following cycle.
- Multi-request: req=4'b1011 for 1 cycle, ready=1.
  - Fixed priority -> codes 0, 1, 3 on 3 consecutive cycles.
  - ENCODE_ROUND_ROBIN_EN with pointer=2 -> codes 3, 0, 1.
- Backpressure: ready=0 while req=4'b0011 is pending -> code=0 held with valid=1; pending=4'b0010 stable. Raise ready -> code 1 the next cycle.
- Overflow and set-wins: pulse req=4'b0001 twice while ready=0 -> overflow=1 (sticky).
- Set-wins at clear: pulse req[0] in the cycle bit0 is loaded -> pending[0] remains 1 and code 0 is emitted twice.
- Enable gate and mid-operation reset: req=4'b1111 with enable=0 -> pending stays 0. Assert reset while valid=1 -> valid=0 and pending=0 next edge.
